// File: rtl/i2c_pkg.sv
// Shared types and timing helpers for the I2C register writer.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA, S_ACK3, S_STOP
  } state_t;

  localparam int NUM_SLOTS = 29;
  localparam int NUM_QTRS  = 4;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
  } wr_req_t;

  function automatic int qtr_calc(input int clk_hz, input int i2c_hz);
    return clk_hz / (4 * i2c_hz);
  endfunction

  function automatic logic is_ack(input state_t s);
    return (s == S_ACK1) || (s == S_ACK2) || (s == S_ACK3);
  endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit divider: tick is high for one cycle every QTR clocks after clr.
module i2c_qtr_tick #(
  parameter int QTR = 210
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(QTR - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/i2c_reg_writer.sv
// Single-register I2C master write: START, {DEV_ADDR,W}, reg_addr, wr_data, STOP.
module i2c_reg_writer
  import i2c_pkg::*;
#(
  parameter int         CLK_IN_HZ = 84_000_000,
  parameter int         I2C_HZ    = 100_000,
  parameter logic [6:0] DEV_ADDR  = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int         QTR   = qtr_calc(CLK_IN_HZ, I2C_HZ);
  localparam logic [1:0] QLAST = 2'(NUM_QTRS - 1);

  state_t     state, state_nxt;
  logic [1:0] q, q_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic       nack, nack_nxt;
  logic       scl_nxt, sda_nxt;
  logic [7:0] cur_byte;
  logic       bit_val;
  logic       tick, accept, slot_end;
  wr_req_t    req;

  // Acceptance looks at the registered busy, so a start coinciding with the
  // final tick is dropped.
  assign accept   = start & ~busy;
  assign slot_end = busy & tick & (q == QLAST);

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    bit_nxt   = bit_cnt;
    nack_nxt  = nack;
    if (state == S_IDLE) begin
      if (accept) begin
        state_nxt = S_START;
        q_nxt     = 2'd0;
        bit_nxt   = 3'd0;
        nack_nxt  = 1'b0;
      end
    end else if (tick) begin
      q_nxt = q + 2'd1;
      if (q == 2'd2 && is_ack(state)) nack_nxt = sda_i;
      if (q == QLAST) begin
        case (state)
          S_START: state_nxt = S_ADDR;
          S_ADDR, S_REG, S_DATA: begin
            bit_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state_nxt = (state == S_ADDR) ? S_ACK1 :
                          (state == S_REG)  ? S_ACK2 : S_ACK3;
          end
          S_ACK1:  state_nxt = nack ? S_STOP : S_REG;
          S_ACK2:  state_nxt = nack ? S_STOP : S_DATA;
          S_ACK3:  state_nxt = S_STOP;
          S_STOP:  state_nxt = S_IDLE;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (state_nxt)
      S_ADDR:  cur_byte = {DEV_ADDR, 1'b0};
      S_REG:   cur_byte = req.reg_addr;
      S_DATA:  cur_byte = req.wr_data;
      default: cur_byte = 8'h00;
    endcase
  end

  assign bit_val = cur_byte[3'd7 - bit_nxt];

  // Line drive is decoded from the upcoming quarter so outputs stay registered.
  always_comb begin
    scl_nxt = 1'b0;
    sda_nxt = 1'b0;
    case (state_nxt)
      S_START: begin
        scl_nxt = (q_nxt == 2'd3);
        sda_nxt = (q_nxt >= 2'd2);
      end
      S_ADDR, S_REG, S_DATA: begin
        scl_nxt = (q_nxt == 2'd0) || (q_nxt == 2'd3);
        sda_nxt = ~bit_val;
      end
      S_ACK1, S_ACK2, S_ACK3: begin
        scl_nxt = (q_nxt == 2'd0) || (q_nxt == 2'd3);
        sda_nxt = 1'b0;
      end
      S_STOP: begin
        scl_nxt = (q_nxt == 2'd0);
        sda_nxt = (q_nxt <= 2'd1);
      end
      default: begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      q       <= 2'd0;
      bit_cnt <= 3'd0;
      nack    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      req     <= '0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      bit_cnt <= bit_nxt;
      nack    <= nack_nxt;
      scl_oe  <= scl_nxt;
      sda_oe  <= sda_nxt;
      done    <= 1'b0;
      if (accept) begin
        busy         <= 1'b1;
        ack_err      <= 1'b0;
        req.reg_addr <= reg_addr;
        req.wr_data  <= wr_data;
      end
      if (slot_end) begin
        if (is_ack(state) && nack) ack_err <= 1'b1;
        if (state == S_STOP) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Randomized bench with a bus-level slave model and protocol monitor.
module tb_i2c_reg_writer;

  localparam int         CLK_HZ = 8_400_000;
  localparam int         SCL_HZ = 100_000;
  localparam int         QTR    = CLK_HZ / (4 * SCL_HZ);
  localparam logic [6:0] DEV    = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       busy, done, ack_err, scl_oe, sda_oe;
  logic       pull = 1'b0;
  wire logic  scl_line = ~scl_oe;
  wire logic  sda_line = ~(sda_oe | pull);

  int n_chk = 0, n_err = 0, prot_err = 0, done_cnt = 0;
  int nack_byte = -1;
  bit mute = 1'b0;
  logic [7:0] rx_q[$];

  logic       scl_p = 1'b1, sda_p = 1'b1, active = 1'b0;
  logic [7:0] shreg = 8'h00;
  int         bitn = 0, byte_idx = 0;

  i2c_reg_writer #(.CLK_IN_HZ(CLK_HZ), .I2C_HZ(SCL_HZ), .DEV_ADDR(DEV)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_addr(reg_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_i(sda_line)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Slave: shifts bits on SCL rise, ACKs (unless told to NACK) after each byte,
  // and flags any SDA edge under high SCL that is not a legal START/STOP.
  always @(posedge clk) begin
    scl_p <= scl_line;
    sda_p <= sda_line;
    if (rst || mute) begin
      active <= 1'b0; bitn <= 0; byte_idx <= 0; pull <= 1'b0;
    end else if (scl_line && scl_p && sda_line != sda_p) begin
      if (!sda_line) begin
        if (active) prot_err <= prot_err + 1;
        active <= 1'b1; bitn <= 0; byte_idx <= 0; pull <= 1'b0;
      end else begin
        if (!active || bitn != 1) prot_err <= prot_err + 1;
        active <= 1'b0;
      end
    end else if (active) begin
      if (scl_line && !scl_p) begin
        if (bitn < 8) shreg <= {shreg[6:0], sda_line};
        bitn <= bitn + 1;
      end else if (!scl_line && scl_p) begin
        if (bitn == 8) begin
          rx_q.push_back(shreg);
          pull <= (byte_idx != nack_byte);
        end else if (bitn == 9) begin
          pull <= 1'b0; bitn <= 0; byte_idx <= byte_idx + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One transaction. nk: byte index the slave NACKs (-1 = none). coll_at: cycle
  // to pulse a stray start (0 = none). pre: start already driven. chain: raise the
  // next start one cycle before done so it lands on the done edge.
  task automatic tx(input logic [7:0] ra, input logic [7:0] wd, input int nk,
                    input int coll_at, input bit pre, input bit chain,
                    input logic [7:0] cra, input logic [7:0] cwd);
    int n, exp_n, lim, nb;
    logic [7:0] eb[3];
    eb[0] = {DEV, 1'b0}; eb[1] = ra; eb[2] = wd;
    nack_byte = nk;
    rx_q.delete();
    if (!pre) begin start = 1'b1; reg_addr = ra; wr_data = wd; end
    @(posedge clk); #1;
    start = 1'b0; reg_addr = 8'($urandom); wr_data = 8'($urandom);
    chk("acc_busy", busy, 1);
    chk("acc_ackerr", ack_err, 0);
    chk("acc_done", done, 0);
    exp_n = (nk < 0 ? 116 : 8 + 36 * (nk + 1)) * QTR;
    lim = 130 * QTR;
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      if (coll_at != 0 && n == coll_at) begin
        start = 1'b1; reg_addr = 8'($urandom); wr_data = 8'($urandom);
      end
      if (coll_at != 0 && n == coll_at + 1) start = 1'b0;
      if (chain && n == exp_n - 1) begin start = 1'b1; reg_addr = cra; wr_data = cwd; end
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, exp_n);
    chk("end_busy", busy, 0);
    chk("end_ackerr", ack_err, (nk >= 0));
    chk("end_scl", scl_oe, 0);
    chk("end_sda", sda_oe, 0);
    nb = (nk < 0) ? 3 : nk + 1;
    chk("nbytes", rx_q.size(), nb);
    for (int i = 0; i < nb && i < rx_q.size(); i++) chk("byte", rx_q[i], eb[i]);
    if (!chain) begin
      @(posedge clk); #1;
      chk("done_1cyc", done, 0);
    end
  endtask

  initial begin
    int d0, tgt, nk;
    logic [7:0] ra, wd;
    // reset with start held high: start must be discarded
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ackerr", ack_err, 0);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);

    tx(8'h00, 8'h2A, -1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    tx(8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    for (int k = 0; k < 6; k++) begin
      nk = int'($urandom_range(0, 3)) - 1;
      tx(8'($urandom), 8'($urandom), nk, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end

    // stray start while busy
    d0 = done_cnt;
    tx(8'($urandom), 8'($urandom), -1, 100, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (200) @(posedge clk);
    #1;
    chk("coll_one_done", done_cnt - d0, 1);
    chk("coll_idle", busy, 0);

    // NACK then back-to-back start
    ra = 8'($urandom); wd = 8'($urandom);
    tx(8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b1, ra, wd);
    tx(ra, wd, -1, 0, 1'b1, 1'b0, 8'h00, 8'h00);

    // reset during the DATA byte
    d0 = done_cnt;
    start = 1'b1; reg_addr = 8'($urandom); wr_data = 8'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    tgt = (80 + int'($urandom_range(0, 24))) * QTR + int'($urandom_range(0, QTR - 1));
    repeat (tgt) @(posedge clk);
    #1;
    mute = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_scl", scl_oe, 0);
    chk("mid_rst_sda", sda_oe, 0);
    chk("mid_rst_done", done, 0);
    repeat (20) @(posedge clk);
    #1;
    mute = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - d0, 0);
    tx(8'($urandom), 8'($urandom), -1, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    chk("protocol", prot_err, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_reg_writer.md
I2C_REG_WRITER -- requirements
Module: i2c_reg_writer

Interface
REQ-001 Parameter CLK_IN_HZ, default 84_000_000, system clock frequency.
REQ-002 Parameter I2C_HZ, default 100_000, SCL frequency.
REQ-003 Parameter DEV_ADDR, default 7'h50, 7-bit slave address.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle write request; sampled only when busy=0.
REQ-007 reg_addr  input  8  target register; captured on accepted start.
REQ-008 wr_data  input  8  byte to write (e.g. seconds count); captured on accepted start.
REQ-009 busy  output  1  high while a transaction is in progress.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 ack_err  output  1  high if any ACK slot sampled SDA=1; held until next accepted start.
REQ-012 scl_oe  output  1  1 = pull SCL low, 0 = release.
REQ-013 sda_oe  output  1  1 = pull SDA low, 0 = release.
REQ-014 sda_i  input  1  SDA line level.

Function
REQ-015 QTR = CLK_IN_HZ/(4*I2C_HZ), integer division (210 at defaults); the quarter tick fires once every QTR clk cycles.
REQ-016 Each bit slot is 4 quarters: q0 SCL low with SDA driven, q1–q2 SCL released, SDA sampled at the end of q2, q3 SCL low.
REQ-017 States are IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP.
REQ-018 The transaction sequence is START, ADDR (DEV_ADDR,0), ACK1, REG (reg_addr), ACK2, DATA (wr_data), ACK3, STOP: 29 slots, 116 quarters.
REQ-019 Bytes are sent MSB first; the bit counter is 3 bits and wraps 7→0 at the end of each byte.
REQ-020 START slot: SDA and SCL released in q0–q1, SDA low in q2, SCL low in q3.
REQ-021 STOP slot: SDA low in q0–q1 with SCL released from q1, SDA released in q2, both released in q3.
REQ-022 ACK slots release SDA (sda_oe=0).
REQ-023 A start sampled at cycle T with busy=0 sets busy=1 at T+1, restarts the divider at T+1, and clears ack_err at T+1.
REQ-024 done=1 and busy=0 occur at T+1+116*QTR; done lasts exactly 1 cycle.
REQ-025 On a NACK, ack_err=1 at the end of that ACK slot; the FSM jumps to STOP and done fires at the end of STOP, so the transaction is shortened.
REQ-026 start while busy=1 is ignored, with no queuing.
REQ-027 start in the same cycle as done is ignored because busy is still 1 at the sample point.
REQ-028 In IDLE, scl_oe=0 and sda_oe=0.
REQ-029 Outputs are registered, with no combinational path from sda_i or start to any output.

Reset
REQ-030 When rst=1 at a clk edge: state=IDLE, busy=0, done=0, ack_err=0, scl_oe=0, sda_oe=0, divider=0, bit counter=0.
REQ-031 Reset mid-transaction aborts immediately and releases both lines; no STOP is generated.
REQ-032 A start asserted in the same cycle as rst is discarded.

Structure
REQ-033 Package i2c_pkg holds the state enum type and the slot/quarter counts (29 slots, 4 quarters).
REQ-034 Package i2c_pkg also holds a function computing QTR from CLK_IN_HZ and I2C_HZ.
REQ-035 One sub-module, i2c_qtr_tick, is instantiated: parameter QTR; ports clk, rst, clr, tick.

Verification
REQ-036 Full write: start with reg_addr=8'h00, wr_data=8'h2A, slave model ACKs all → SDA bytes A0, 00, 2A; done at T+1+24360; ack_err=0.
REQ-037 NACK on address: slave never pulls SDA → ack_err=1 after ACK1, STOP follows, done at T+1+(1+9+1)*4*210=T+1+9240.
REQ-038 Busy collision: start pulse at T+100 during a transaction → ignored; only one transaction and one done pulse are seen.
REQ-039 Back-to-back: start in the done cycle is ignored; start one cycle later is accepted; ack_err from a prior NACK clears at accept+1.
REQ-040 Mid-operation reset: rst during the DATA slot → next cycle busy=0, scl_oe=0, sda_oe=0, no done pulse; a new start then works normally.
REQ-041 Protocol checker: SDA changes only while SCL is low, except the START (SDA falls, SCL high) and STOP (SDA rises, SCL high) events.
